// File: rtl/axi_write_arbiter_if.sv
// Bus bundle for axi_write_arbiter: N upstream AW/W requesters on one side,
// a single downstream AW/W port on the other, plus route-FIFO occupancy.
//   slave  : arbiter view (takes upstream valids, drives downstream)
//   master : environment view (drives upstream, consumes downstream)
interface axi_write_arbiter_if #(
   parameter int unsigned NumInp   = 2,
   parameter int unsigned AwWidth  = 64,
   parameter int unsigned WWidth   = 72,
   parameter int unsigned MaxWTxns = 4
);
   localparam int unsigned IdxW = (NumInp > 1) ? $clog2(NumInp) : 1;
   localparam int unsigned CntW = $clog2(MaxWTxns + 1);

   logic [NumInp-1:0]         inp_aw_valid_i;
   logic [NumInp*AwWidth-1:0] inp_aw_i;
   logic [NumInp-1:0]         inp_aw_ready_o;
   logic [NumInp-1:0]         inp_w_valid_i;
   logic [NumInp*WWidth-1:0]  inp_w_i;
   logic [NumInp-1:0]         inp_w_last_i;
   logic [NumInp-1:0]         inp_w_ready_o;

   logic                      oup_aw_valid_o;
   logic [AwWidth-1:0]        oup_aw_o;
   logic [IdxW-1:0]           oup_aw_sel_o;
   logic                      oup_aw_ready_i;
   logic                      oup_w_valid_o;
   logic [WWidth-1:0]         oup_w_o;
   logic                      oup_w_last_o;
   logic                      oup_w_ready_i;

   logic [CntW-1:0]           w_pending_o;

   modport slave (
      input  inp_aw_valid_i, inp_aw_i, inp_w_valid_i, inp_w_i, inp_w_last_i,
             oup_aw_ready_i, oup_w_ready_i,
      output inp_aw_ready_o, inp_w_ready_o, oup_aw_valid_o, oup_aw_o, oup_aw_sel_o,
             oup_w_valid_o, oup_w_o, oup_w_last_o, w_pending_o
   );

   modport master (
      output inp_aw_valid_i, inp_aw_i, inp_w_valid_i, inp_w_i, inp_w_last_i,
             oup_aw_ready_i, oup_w_ready_i,
      input  inp_aw_ready_o, inp_w_ready_o, oup_aw_valid_o, oup_aw_o, oup_aw_sel_o,
             oup_w_valid_o, oup_w_o, oup_w_last_o, w_pending_o
   );
endinterface

// File: rtl/axi_write_arbiter.sv
// axi_write_arbiter: shares one downstream AXI write port (AW + W) between
// NumInp requesters. Round-robin on AW; W bursts follow granted-AW order via a
// route FIFO of input indices, so bursts never interleave downstream.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous reset, active low
//   bus     axi_write_arbiter_if.slave (upstream AW/W, downstream AW/W,
//           oup_aw_sel_o for a B demux, w_pending_o = route-FIFO occupancy)
//
// AW grant FSM:
//   state   | meaning
//   ST_ARB  | grant chosen combinationally, round-robin from rr pointer
//   ST_LOCK | downstream stalled a valid AW; grant held until handshake
module axi_write_arbiter #(
   parameter int unsigned NumInp   = 2,
   parameter int unsigned AwWidth  = 64,
   parameter int unsigned WWidth   = 72,
   parameter int unsigned MaxWTxns = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   axi_write_arbiter_if.slave  bus
);
   localparam int unsigned IdxW = (NumInp > 1) ? $clog2(NumInp) : 1;
   localparam int unsigned CntW = $clog2(MaxWTxns + 1);
   localparam int unsigned PtrW = (MaxWTxns > 1) ? $clog2(MaxWTxns) : 1;

   typedef enum logic {ST_ARB, ST_LOCK} state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] lock_idx_q, lock_idx_d;
   logic [IdxW-1:0] rr_q, rr_d;
   logic [IdxW-1:0] winner, idx, sel, head;
   logic            any_req, aw_valid, aw_hs, push, pop, full, empty;

   logic [IdxW-1:0] fifo_q [MaxWTxns];
   logic [PtrW-1:0] wr_q, rd_q;
   logic [CntW-1:0] cnt_q;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxWTxns - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign full  = (cnt_q == CntW'(MaxWTxns));
   assign empty = (cnt_q == '0);
   assign head  = fifo_q[rd_q];

   // Scan from highest offset down so the lowest offset from rr_q wins.
   always_comb begin
      winner  = '0;
      idx     = '0;
      any_req = 1'b0;
      for (int i = int'(NumInp) - 1; i >= 0; i--) begin
         idx = IdxW'((int'(rr_q) + i) % int'(NumInp));
         if (bus.inp_aw_valid_i[idx]) begin
            winner  = idx;
            any_req = 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      rr_d       = rr_q;

      if (state_q == ST_LOCK) sel = lock_idx_q;
      else if (any_req)       sel = winner;
      else                    sel = rr_q;

      // Gated by rst_ni so no request leaks out while reset is asserted.
      aw_valid = rst_ni && !full && bus.inp_aw_valid_i[sel];
      aw_hs    = aw_valid && bus.oup_aw_ready_i;

      case (state_q)
         ST_ARB: begin
            if (aw_valid && !bus.oup_aw_ready_i) begin
               state_d    = ST_LOCK;
               lock_idx_d = sel;
            end
         end
         ST_LOCK: begin
            if (aw_hs) state_d = ST_ARB;
         end
         default: state_d = ST_ARB;
      endcase

      if (aw_hs) rr_d = IdxW'((int'(sel) + 1) % int'(NumInp));

      bus.oup_aw_valid_o = aw_valid;
      bus.oup_aw_sel_o   = sel;
      bus.oup_aw_o       = bus.inp_aw_i[int'(sel)*AwWidth +: AwWidth];
      bus.inp_aw_ready_o = '0;
      if (rst_ni && !full) bus.inp_aw_ready_o[sel] = bus.oup_aw_ready_i;
   end

   always_comb begin
      bus.inp_w_ready_o = '0;
      bus.oup_w_valid_o = !empty && bus.inp_w_valid_i[head];
      bus.oup_w_o       = bus.inp_w_i[int'(head)*WWidth +: WWidth];
      bus.oup_w_last_o  = bus.inp_w_last_i[head];
      if (!empty) bus.inp_w_ready_o[head] = bus.oup_w_ready_i;
   end

   assign push            = aw_hs;
   assign pop             = bus.oup_w_valid_o && bus.oup_w_ready_i && bus.oup_w_last_o;
   assign bus.w_pending_o = cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_ARB;
         lock_idx_q <= '0;
         rr_q       <= '0;
      end else begin
         state_q    <= state_d;
         lock_idx_q <= lock_idx_d;
         rr_q       <= rr_d;
      end
   end

   // Push is already blocked by the registered full flag, so a same-cycle
   // pop never makes room for a push.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < int'(MaxWTxns); i++) fifo_q[i] <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_q] <= sel;
            wr_q         <= ptr_inc(wr_q);
         end
         if (pop) rd_q <= ptr_inc(rd_q);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CntW'(1);
            2'b01:   cnt_q <= cnt_q - CntW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule
